// File: rtl/btn_evt_pkg.sv
// Shared constants for the button-event port: bus select codes and the
// bit layout of event and status words.
package btn_evt_pkg;

  localparam logic SEL_STATUS = 1'b0;
  localparam logic SEL_DATA   = 1'b1;

  localparam int EVT_VLD_BIT = 31;
  localparam int EVT_REL_BIT = 30;
  localparam int EVT_IDX_LSB = 24;
  localparam int EVT_IDX_W   = 3;

  localparam int STAT_OVF_BIT   = 31;
  localparam int STAT_EMPTY_BIT = 30;
  localparam int STAT_FULL_BIT  = 29;
  localparam int STAT_LVL_LSB   = 16;
  localparam int STAT_CNT_W     = 5;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser plus a saturating debounce counter.
// ready rises once DB_CNT differing samples are seen; the stable level flips only on commit.
module btn_debounce #(
  parameter int DB_CNT = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn,
  input  logic sample_en,
  input  logic commit,
  output logic ready,
  output logic level
);

  localparam int CNT_W = $clog2(DB_CNT + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  assign ready = (cnt == CNT_W'(DB_CNT));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      // A waiting button holds its saturated count until the arbiter picks it.
      if (commit) begin
        level <= ~level;
        cnt   <= '0;
      end else if (sample_en) begin
        if (sync2 == level) begin
          cnt <= '0;
        end else if (!ready) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/btn_event_port.sv
// Button-event port: debounced press/release events, timestamped and queued for CPU reads.
// Read data is registered one clk after bus_rd; events arriving on a full FIFO are dropped and flagged.
module btn_event_port
  import btn_evt_pkg::*;
#(
  parameter int NBTN   = 5,
  parameter int DEPTH  = 8,
  parameter int DB_CNT = 4,
  parameter int TS_W   = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NBTN-1:0] btn_i,
  input  logic            sample_en,
  input  logic            bus_rd,
  input  logic            bus_sel,
  output logic [31:0]     bus_rdata,
  output logic            irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [NBTN-1:0]      ready;
  logic [NBTN-1:0]      commit;
  logic [NBTN-1:0]      level;
  logic [31:0]          mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [TS_W-1:0]      ts;
  logic                 ovf;
  logic                 empty;
  logic                 full;
  logic                 push_req;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic                 rel;
  logic [EVT_IDX_W-1:0] cidx;
  logic [31:0]          evt;
  logic [31:0]          status;

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    btn_debounce #(.DB_CNT(DB_CNT)) u_db (
      .clk       (clk),
      .rstn      (rstn),
      .btn       (btn_i[g]),
      .sample_en (sample_en),
      .commit    (commit[g]),
      .ready     (ready[g]),
      .level     (level[g])
    );
  end

  // Fixed priority: lowest ready index wins, others wait for later cycles.
  always_comb begin
    commit   = '0;
    cidx     = '0;
    rel      = 1'b0;
    push_req = 1'b0;
    for (int i = 0; i < NBTN; i++) begin
      if (ready[i] && !push_req) begin
        push_req  = 1'b1;
        commit[i] = 1'b1;
        cidx      = EVT_IDX_W'(i);
        rel       = level[i];
      end
    end
  end

  always_comb begin
    evt                              = '0;
    evt[EVT_VLD_BIT]                 = 1'b1;
    evt[EVT_REL_BIT]                 = rel;
    evt[EVT_IDX_LSB +: EVT_IDX_W]    = cidx;
    evt[TS_W-1:0]                    = ts;
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = bus_rd && (bus_sel == SEL_DATA) && !empty;
  assign push  = push_req && (!full || pop);
  assign drop  = push_req && full && !pop;

  always_comb begin
    status                          = '0;
    status[STAT_OVF_BIT]            = ovf;
    status[STAT_EMPTY_BIT]          = empty;
    status[STAT_FULL_BIT]           = full;
    status[STAT_LVL_LSB +: NBTN]    = level;
    status[STAT_CNT_W-1:0]          = STAT_CNT_W'(count);
  end

  always_ff @(posedge clk) begin
    if (rstn && push) begin
      mem[wr_ptr] <= evt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      ts        <= '0;
      bus_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      if (sample_en) begin
        ts <= ts + TS_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A drop in the same cycle as a STATUS read keeps the flag set.
      if (drop) begin
        ovf <= 1'b1;
      end else if (bus_rd && (bus_sel == SEL_STATUS)) begin
        ovf <= 1'b0;
      end
      if (bus_rd) begin
        bus_rdata <= (bus_sel == SEL_DATA) ? (empty ? 32'h0 : mem[rd_ptr]) : status;
      end
      irq <= !empty;
    end
  end

endmodule

// File: tb/tb_btn_event_port.sv
// Scoreboard bench for btn_event_port: a per-cycle reference model queues expected read data and irq.
module tb_btn_event_port;

  localparam int NBTN   = 5;
  localparam int DEPTH  = 8;
  localparam int DB_CNT = 4;
  localparam int TS_W   = 16;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NBTN-1:0] btn_i;
  logic            sample_en;
  logic            bus_rd;
  logic            bus_sel;
  logic [31:0]     bus_rdata;
  logic            irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  btn_event_port #(
    .NBTN(NBTN), .DEPTH(DEPTH), .DB_CNT(DB_CNT), .TS_W(TS_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .btn_i     (btn_i),
    .sample_en (sample_en),
    .bus_rd    (bus_rd),
    .bus_sel   (bus_sel),
    .bus_rdata (bus_rdata),
    .irq       (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]     m_q[$];
  logic [31:0]     exp_q[$];
  int              m_cnt[NBTN];
  logic [NBTN-1:0] m_stable;
  logic [NBTN-1:0] m_s1;
  logic [NBTN-1:0] m_s2;
  int              m_ts;
  bit              m_ovf;
  bit              m_irq;
  bit              m_live = 1'b0;

  function automatic bit m_any_ready();
    for (int i = 0; i < NBTN; i++) begin
      if (m_cnt[i] == DB_CNT) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    int          who;
    logic [31:0] v;
    bit          drop;
    bit          irq_n;
    if (!rstn) begin
      m_q.delete();
      m_stable = '0;
      m_s1     = '0;
      m_s2     = '0;
      for (int i = 0; i < NBTN; i++) m_cnt[i] = 0;
      m_ts   = 0;
      m_ovf  = 1'b0;
      m_irq  = 1'b0;
      m_live = 1'b1;
    end else begin
      who = -1;
      for (int i = NBTN - 1; i >= 0; i--) begin
        if (m_cnt[i] == DB_CNT) who = i;
      end
      irq_n = (m_q.size() != 0);
      if (bus_rd) begin
        if (bus_sel) begin
          v = (m_q.size() != 0) ? m_q[0] : 32'h0;
        end else begin
          v = (32'(m_ovf) << 31) | (32'(m_q.size() == 0) << 30) |
              (32'(m_q.size() == DEPTH) << 29) | (32'(m_stable) << 16) | 32'(m_q.size());
        end
        exp_q.push_back(v);
      end
      if (bus_rd && bus_sel && m_q.size() != 0) void'(m_q.pop_front());
      drop = 1'b0;
      if (who >= 0) begin
        v = 32'h8000_0000 | (32'(m_stable[who]) << 30) | (32'(who) << 24) | 32'(m_ts);
        if (m_q.size() < DEPTH) m_q.push_back(v);
        else drop = 1'b1;
        m_stable[who] = ~m_stable[who];
        m_cnt[who]    = 0;
      end
      if (drop) m_ovf = 1'b1;
      else if (bus_rd && !bus_sel) m_ovf = 1'b0;
      if (sample_en) begin
        for (int i = 0; i < NBTN; i++) begin
          if (i != who) begin
            if (m_s2[i] == m_stable[i]) m_cnt[i] = 0;
            else if (m_cnt[i] < DB_CNT) m_cnt[i] = m_cnt[i] + 1;
          end
        end
        m_ts = (m_ts + 1) % (1 << TS_W);
      end
      m_s2  = m_s1;
      m_s1  = btn_i;
      m_irq = irq_n;
    end
  end

  // ---------------- monitor ----------------
  bit rd_d = 1'b0;
  always @(posedge clk) rd_d <= bus_rd;

  always @(negedge clk) begin
    if (rd_d) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rdata_unexpected: got %h, expected no read response", bus_rdata);
      end else begin
        check("rdata", bus_rdata, exp_q.pop_front());
      end
    end
    if (m_live) check("irq", 32'(irq), 32'(m_irq));
  end

  // ---------------- stimulus ----------------
  initial begin
    int se_cnt;
    se_cnt = 0;
    sample_en = 1'b0;
    forever begin
      @(negedge clk);
      se_cnt++;
      sample_en = (se_cnt % 4 == 0);
    end
  end

  task automatic rd(input logic sel, output logic [31:0] d);
    bus_rd  = 1'b1;
    bus_sel = sel;
    @(negedge clk);
    bus_rd  = 1'b0;
    d = bus_rdata;
  endtask

  task automatic do_reset();
    rstn   = 1'b0;
    bus_rd = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    check("reset_rdata", bus_rdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] d0;
    logic [15:0] tsd;
    bit          found;
    int          hold;
    int          b;
    rstn    = 1'b0;
    btn_i   = '0;
    bus_rd  = 1'b0;
    bus_sel = 1'b0;
    @(negedge clk);

    // 1: reset state
    do_reset();
    rd(1'b0, d);
    check("t1_status", d, 32'h4000_0000);

    // 2: press and release of button 2
    btn_i[2] = 1'b1;
    repeat (30) @(negedge clk);
    rd(1'b1, d);
    check("t2_press", d & 32'hFFFF_0000, 32'h8200_0000);
    check("t2_irq_hold", 32'(irq), 32'h1);
    @(negedge clk);
    check("t2_irq_fall", 32'(irq), 32'h0);
    btn_i[2] = 1'b0;
    repeat (30) @(negedge clk);
    rd(1'b1, d);
    check("t2_release", d & 32'hFFFF_0000, 32'hC200_0000);

    // 3: short glitches on button 1 never commit
    repeat (3) begin
      btn_i[1] = 1'b1;
      repeat (8) @(negedge clk);
      btn_i[1] = 1'b0;
      repeat (16) @(negedge clk);
    end
    rd(1'b0, d);
    check("t3_status", d & 32'h0002_001F, 32'h0);

    // 4: simultaneous rise on buttons 0 and 3
    btn_i = 5'b01001;
    repeat (30) @(negedge clk);
    rd(1'b1, d0);
    rd(1'b1, d);
    check("t4_first", d0 & 32'hFF00_0000, 32'h8000_0000);
    check("t4_second", d & 32'hFF00_0000, 32'h8300_0000);
    tsd = d[15:0] - d0[15:0];
    check("t4_tsdiff_le1", 32'(tsd <= 16'd1), 32'h1);

    // 5: nine events into an eight-deep FIFO
    btn_i = '0;
    do_reset();
    btn_i = '1;
    repeat (40) @(negedge clk);
    btn_i = 5'h10;
    repeat (40) @(negedge clk);
    rd(1'b0, d);
    check("t5_status_ovf", d & 32'hE000_001F, 32'hA000_0008);
    rd(1'b0, d);
    check("t5_ovf_cleared", d & 32'h8000_0000, 32'h0);

    // 6: pop in the same cycle as a commit while full
    btn_i = '0;
    found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      if (m_any_ready() && m_q.size() == DEPTH) begin
        found = 1'b1;
        rd(1'b1, d);
      end else begin
        @(negedge clk);
      end
    end
    check("t6_align", 32'(found), 32'h1);
    rd(1'b0, d);
    check("t6_status", d & 32'hE000_001F, 32'h2000_0008);
    repeat (5) rd(1'b1, d);
    rd(1'b0, d);
    check("t6_count3", d & 32'h0000_001F, 32'h3);
    do_reset();
    rd(1'b0, d);
    check("t6_status_after_reset", d, 32'h4000_0000);
    rd(1'b1, d);
    check("t6_data_empty", d, 32'h0);

    // random phase
    for (int it = 0; it < 120; it++) begin
      if (it == 60) do_reset();
      hold = $urandom_range(1, 40);
      if ($urandom_range(0, 2) == 0) begin
        btn_i = NBTN'($urandom);
      end else begin
        b = $urandom_range(0, NBTN - 1);
        btn_i[b] = ~btn_i[b];
      end
      for (int c = 0; c < hold; c++) begin
        bus_rd  = ($urandom_range(0, 5) == 0);
        bus_sel = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      bus_rd = 1'b0;
    end

    bus_rd = 1'b0;
    repeat (4) @(negedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
